// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared op, FSM state and flag-index definitions for the ARM-path ALU
// Purpose: common encodings imported by arm_alu_mc and arm_mul_iter.
// Ports: none (package).
package arm_pkg;

   // inst[14:12] op encodings; 3'b111 behaves like OP_PASS
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MOV  = 3'b010;
   localparam logic [2:0] OP_LSR  = 3'b011;
   localparam logic [2:0] OP_DEC  = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_PASS = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // bit positions inside flags = {N,Z,C,V}
   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

endpackage

// File: rtl/arm_mul_iter.sv
// rtl/arm_mul_iter.sv - WIDTH-cycle shift-add multiplier owning acc, A, B and the iteration count
// Purpose: low WIDTH bits of a_in*b_in, one shift-add step per cycle after start.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   start         load operands, clear acc and cnt, begin iterating
//   a_in, b_in    operands sampled on start
//   last          high during the final iteration; product is the result loaded at that edge
//   product       acc after the current iteration (acc + A when B[0])
module arm_mul_iter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             last,
   output logic [WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [CNT_W-1:0] cnt;
   logic             running;

   // Carry out of acc is dropped: the product is truncated to WIDTH bits.
   assign product = acc + (b_q[0] ? a_q : '0);
   assign last    = running && (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cnt     <= '0;
         running <= 1'b0;
      end else if (start) begin
         acc     <= '0;
         a_q     <= a_in;
         b_q     <= b_in;
         cnt     <= '0;
         running <= 1'b1;
      end else if (running) begin
         acc     <= product;
         a_q     <= a_q << 1;
         b_q     <= b_q >> 1;
         cnt     <= cnt + 1'b1;
         if (last) begin
            running <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/arm_alu_mc.sv
// rtl/arm_alu_mc.sv - registered ARM-path ALU with multi-cycle multiply, NZCV flags and write-back decode
// Purpose: accepts one instruction per start when idle, returns result with a one-cycle done pulse.
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   start, inst       instruction accept ([15] arm, [14:12] op, [11] cin)
//   rd_data, rs_data  operands A and B
//   busy              multiply in progress
//   done, d_out       result-valid pulse and held result
//   flags             {N,Z,C,V}, updated together with done
//   wen, ldr, reg_mux write-back controls
module arm_alu_mc
   import arm_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [15:0]      inst,
   input  logic [WIDTH-1:0] rd_data,
   input  logic [WIDTH-1:0] rs_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d_out,
   output logic [3:0]       flags,
   output logic             wen,
   output logic             ldr,
   output logic             reg_mux
);

   state_t           state;
   state_t           state_nxt;
   logic [2:0]       op;
   logic             cin;
   logic             accept;
   logic             mul_start;
   logic             mul_last;
   logic [WIDTH-1:0] mul_product;
   logic             arm_q;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_res;
   logic [3:0]       alu_flags;
   logic [3:0]       mul_flags;
   logic             unused_inst;

   assign op          = inst[14:12];
   assign cin         = inst[11];
   assign unused_inst = ^inst[10:0];
   assign accept      = (state == ST_IDLE) && start;
   assign mul_start   = accept && (op == OP_MUL);

   arm_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (mul_start),
      .a_in    (rd_data),
      .b_in    (rs_data),
      .last    (mul_last),
      .product (mul_product)
   );

   // Single-cycle ops; sum is WIDTH+1 bits so its MSB is the carry out.
   always_comb begin
      sum       = '0;
      alu_res   = rd_data;
      alu_flags = '0;
      case (op)
         OP_ADD: begin
            sum              = {1'b0, rd_data} + {1'b0, rs_data};
            alu_res          = sum[WIDTH-1:0];
            alu_flags[FLG_C] = sum[WIDTH];
            alu_flags[FLG_V] = (rd_data[WIDTH-1] == rs_data[WIDTH-1]) &&
                               (alu_res[WIDTH-1] != rd_data[WIDTH-1]);
         end
         OP_SUB: begin
            sum              = {1'b0, rd_data} + {1'b0, ~rs_data} + (WIDTH+1)'(1);
            alu_res          = sum[WIDTH-1:0];
            alu_flags[FLG_C] = sum[WIDTH];
            alu_flags[FLG_V] = (rd_data[WIDTH-1] != rs_data[WIDTH-1]) &&
                               (alu_res[WIDTH-1] != rd_data[WIDTH-1]);
         end
         OP_MOV: begin
            sum              = {1'b0, rs_data} + (WIDTH+1)'(cin);
            alu_res          = sum[WIDTH-1:0];
            alu_flags[FLG_C] = sum[WIDTH];
         end
         OP_LSR: begin
            alu_res          = {1'b0, rs_data[WIDTH-1:1]};
            alu_flags[FLG_C] = rs_data[0];
         end
         OP_DEC: begin
            sum              = {1'b0, rs_data} + {1'b0, {WIDTH{1'b1}}};
            alu_res          = sum[WIDTH-1:0];
            alu_flags[FLG_C] = sum[WIDTH];
         end
         OP_PASS: alu_res = rd_data;
         default: alu_res = rd_data;
      endcase
      alu_flags[FLG_N] = alu_res[WIDTH-1];
      alu_flags[FLG_Z] = (alu_res == '0);
   end

   always_comb begin
      mul_flags        = '0;
      mul_flags[FLG_N] = mul_product[WIDTH-1];
      mul_flags[FLG_Z] = (mul_product == '0);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = (op == OP_MUL) ? ST_BUSY : ST_DONE;
         ST_BUSY: if (mul_last) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Result, flags and done load on the edge that enters DONE, so they
   // are visible during the DONE cycle and held afterwards.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         done    <= 1'b0;
         d_out   <= '0;
         flags   <= '0;
         arm_q   <= 1'b0;
         ldr     <= 1'b0;
         reg_mux <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            arm_q   <= inst[15];
            ldr     <= (inst[15:12] == 4'b1110);
            reg_mux <= (inst[15:13] == 3'b001);
            if (op != OP_MUL) begin
               done  <= 1'b1;
               d_out <= alu_res;
               flags <= alu_flags;
            end
         end else if (state == ST_BUSY && mul_last) begin
            done  <= 1'b1;
            d_out <= mul_product;
            flags <= mul_flags;
         end
      end
   end

   assign busy = (state == ST_BUSY);
   assign wen  = done & (arm_q | ldr);

endmodule

// File: tb/tb_arm_alu_mc.sv
// tb/tb_arm_alu_mc.sv - directed self-checking bench for arm_alu_mc at WIDTH=16
module tb_arm_alu_mc;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [15:0] inst;
   logic [15:0] rd_data;
   logic [15:0] rs_data;
   logic        busy;
   logic        done;
   logic [15:0] d_out;
   logic [3:0]  flags;
   logic        wen;
   logic        ldr;
   logic        reg_mux;

   int n_tests = 0;
   int n_fail  = 0;

   arm_alu_mc #(.WIDTH(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .inst    (inst),
      .rd_data (rd_data),
      .rs_data (rs_data),
      .busy    (busy),
      .done    (done),
      .d_out   (d_out),
      .flags   (flags),
      .wen     (wen),
      .ldr     (ldr),
      .reg_mux (reg_mux)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one instruction for a single accept edge.
   task automatic issue(input logic [15:0] i, input logic [15:0] a, input logic [15:0] b);
      inst    = i;
      rd_data = a;
      rs_data = b;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   // Called right after issue() of a multiply; lat counts edges from the accept edge.
   task automatic wait_done(input bit inject, output int lat, output int bcnt);
      lat  = 1;
      bcnt = busy ? 1 : 0;
      while (!done && lat < 40) begin
         if (inject && lat == 4) begin
            inst    = 16'h8000;
            rd_data = 16'h0001;
            rs_data = 16'h0001;
            start   = 1'b1;
         end
         tick();
         start = 1'b0;
         lat++;
         if (busy) bcnt++;
      end
   endtask

   initial begin
      int lat;
      int bcnt;
      int seen;

      reset_n = 1'b0;
      start   = 1'b0;
      inst    = '0;
      rd_data = '0;
      rs_data = '0;
      tick();
      tick();
      check("rst_dout",   d_out,   16'h0000);
      check("rst_flags",  flags,   4'b0000);
      check("rst_done",   done,    1'b0);
      check("rst_busy",   busy,    1'b0);
      check("rst_wen",    wen,     1'b0);
      check("rst_ldr",    ldr,     1'b0);
      check("rst_regmux", reg_mux, 1'b0);
      reset_n = 1'b1;
      tick();

      // add with signed overflow; a start during DONE must be dropped
      issue(16'h8000, 16'h7FFF, 16'h0001);
      check("add_done",  done,  1'b1);
      check("add_dout",  d_out, 16'h8000);
      check("add_flags", flags, 4'b1001);
      check("add_wen",   wen,   1'b1);
      issue(16'h8000, 16'h0001, 16'h0001);
      check("add_dropped_done", done,  1'b0);
      check("add_hold_dout",    d_out, 16'h8000);
      check("add_wen_off",      wen,   1'b0);
      tick();

      issue(16'h9000, 16'h1234, 16'h1234);
      check("sub_done",  done,  1'b1);
      check("sub_dout",  d_out, 16'h0000);
      check("sub_flags", flags, 4'b0110);
      check("sub_wen",   wen,   1'b1);
      tick();

      issue(16'h1000, 16'h1234, 16'h1234);
      check("sub_noarm_done", done, 1'b1);
      check("sub_noarm_wen",  wen,  1'b0);
      tick();

      // mov with cin wrapping to zero
      issue(16'hA800, 16'h0000, 16'hFFFF);
      check("mov_dout",  d_out, 16'h0000);
      check("mov_flags", flags, 4'b0110);
      tick();

      issue(16'hC000, 16'h0000, 16'h0000);
      check("dec_dout",  d_out, 16'hFFFF);
      check("dec_flags", flags, 4'b1000);
      tick();

      issue(16'hB000, 16'h0000, 16'h0003);
      check("lsr_dout",  d_out, 16'h0001);
      check("lsr_flags", flags, 4'b0010);
      tick();

      issue(16'hE000, 16'h5A5A, 16'h0000);
      check("ldr_dout",   d_out,   16'h5A5A);
      check("ldr_flags",  flags,   4'b0000);
      check("ldr_ldr",    ldr,     1'b1);
      check("ldr_wen",    wen,     1'b1);
      check("ldr_regmux", reg_mux, 1'b0);
      tick();

      issue(16'h2000, 16'h0000, 16'h0042);
      check("rm_dout",   d_out,   16'h0042);
      check("rm_regmux", reg_mux, 1'b1);
      check("rm_ldr",    ldr,     1'b0);
      check("rm_wen",    wen,     1'b0);
      tick();

      // multiply 3*5 with a dropped start at cycle 4 of BUSY
      issue(16'hD000, 16'h0003, 16'h0005);
      check("mul1_busy0", busy, 1'b1);
      check("mul1_done0", done, 1'b0);
      wait_done(1'b1, lat, bcnt);
      check("mul1_lat",   lat,   17);
      check("mul1_bcnt",  bcnt,  16);
      check("mul1_dout",  d_out, 16'h000F);
      check("mul1_flags", flags, 4'b0000);
      check("mul1_wen",   wen,   1'b1);
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (done) seen++;
      end
      check("mul1_no_extra_done", seen,  0);
      check("mul1_hold_dout",     d_out, 16'h000F);

      issue(16'hD000, 16'hFFFF, 16'hFFFF);
      wait_done(1'b0, lat, bcnt);
      check("mul2_lat",   lat,   17);
      check("mul2_dout",  d_out, 16'h0001);
      check("mul2_flags", flags, 4'b0000);
      tick();

      issue(16'hD000, 16'h1234, 16'h0000);
      wait_done(1'b0, lat, bcnt);
      check("mul0_lat",   lat,   17);
      check("mul0_dout",  d_out, 16'h0000);
      check("mul0_flags", flags, 4'b0100);
      tick();

      // reset in BUSY cycle 8 aborts the multiply
      issue(16'hD000, 16'h0003, 16'h0005);
      for (int k = 0; k < 7; k++) tick();
      check("abort_busy_pre", busy, 1'b1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 24; k++) begin
         tick();
         if (done) seen++;
      end
      check("abort_no_done", seen,  0);
      check("abort_dout",    d_out, 16'h0000);
      check("abort_flags",   flags, 4'b0000);
      check("abort_busy",    busy,  1'b0);
      check("abort_ldr",     ldr,   1'b0);

      // start coincident with reset: reset wins
      reset_n = 1'b0;
      issue(16'h8000, 16'h0001, 16'h0001);
      check("rst_start_done", done,  1'b0);
      check("rst_start_dout", d_out, 16'h0000);
      reset_n = 1'b1;
      tick();
      check("rst_start_idle", busy | done, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
